jk_bank_sequencer: RTL and testbench
====================================

// Module: jk_bank_sequencer
// PURPOSE
//  Sequences a WIDTH-bit bank of JK flip-flops (posedge clk, async reset) shared by two requesters.
//  Each requester issues one masked op (HOLD/CLR/SET/TOG) via a req/done handshake.
//  A round-robin arbiter grants one requester. A 4-state FSM applies J/K for exactly one cycle.
//  The FSM then captures the bank's updated Q and returns it as rdata.
// PARAMETERS
//  WIDTH   4   number of JK flip-flops in the controlled bank (1..32)
// PORTS
//  clk       in   1        single clock; all state updates on posedge
//  reset     in   1        asynchronous, active-high; clears all state immediately
//  req       in   2        req[i]: requester i has an op pending; held until done[i]
//  op0       in   2        requester 0 op: 00 HOLD, 01 CLR, 10 SET, 11 TOG
//  mask0     in   WIDTH    requester 0 bit select; 1 = apply op to that bit
//  op1       in   2        requester 1 op, same encoding
//  mask1     in   WIDTH    requester 1 bit select
//  q_in      in   WIDTH    Q outputs of the JK bank
//  jk_j      out  WIDTH    J inputs to the bank
//  jk_k      out  WIDTH    K inputs to the bank
//  done      out  2        done[i]: 1-cycle pulse, op of requester i complete
//  rdata     out  WIDTH    bank Q captured after the op; valid while done != 0
//  busy      out  1        1 in any state other than IDLE
// BEHAVIOUR
//  Reset values: jk_j=0, jk_k=0, done=0, rdata=0, busy=0, state=IDLE, rr_ptr=0 (requester 0 favoured).
//  All outputs are registered. jk_j and jk_k are 0 in every state except APPLY.
//  States and transitions:
//   IDLE    req==0: stay. Otherwise grant one requester, latch op/mask/id, go to APPLY.
//   APPLY   Drive jk_j/jk_k from the latched op for this one cycle only. Go to CAPTURE.
//   CAPTURE rdata <= q_in, sampled after the bank has updated. Go to DONE.
//   DONE    done[id]=1 for one cycle. rr_ptr <= ~id. Go to IDLE.
//  Per-bit J/K encoding for masked bits (mask=1):
//   HOLD -> J=0, K=0
//   CLR  -> J=0, K=1
//   SET  -> J=1, K=0
//   TOG  -> J=1, K=1
//  Unmasked bits: J=0, K=0.
//  Latency: req first sampled in IDLE at cycle 0 -> APPLY in cycle 1 -> bank updates at end of cycle 1.
//   CAPTURE in cycle 2; done and rdata in cycle 3. Back-to-back ops: one grant per 4 cycles.
//  Arbitration:
//   Only one request active: that requester is granted.
//   Both active: grant req[rr_ptr].
//   rr_ptr flips to the other requester only on DONE.
//  Handshake rules:
//   op/mask are latched at grant; later changes are ignored.
//   A req dropped mid-transaction does not abort the op; done still pulses.
//   The requester must drop req in the cycle after done. If it is still high in IDLE, it is a new request.
//  Boundary conditions:
//   mask==0 or op==HOLD: full 4-cycle sequence runs; bank unchanged; rdata = current Q.
//   Reset asserted in any state: outputs clear asynchronously and no done is issued.
//    The op in flight is lost; if reset hit in APPLY, the bank may or may not have sampled J/K.
//   busy=1 in APPLY, CAPTURE and DONE.
// STRUCTURE
//  Shared package jk_ctrl_pkg: op encodings (OP_HOLD/CLR/SET/TOG), FSM state encoding,
//   and a function op_to_jk(op, mask) -> {j, k}.
//  Sub-module jk_rr_arb2 provides the 2-way round-robin grant: inputs req[1:0] and rr_ptr, output grant id.
//  The JK bank itself is instantiated outside this block; its Q is fed back on q_in.
// TESTING
//  Bench instantiates this block plus a WIDTH=4 JK bank on the same clk/reset.
//  1 Reset, then req=01, op0=SET, mask0=4'b0101 -> jk_j=0101, jk_k=0000 in cycle 1;
//    done=01, rdata=0101 in cycle 3.
//  2 From Q=0101: req=10, op1=TOG, mask1=4'b1111 -> jk_j=jk_k=1111 in APPLY; done=10, rdata=1010.
//  3 req=11 held from reset -> order of done: req0, req1, req0; each done exactly 4 cycles apart.
//  4 op0=CLR, mask0=4'b0000 from Q=1010 -> jk_j=jk_k=0 throughout; done=01, rdata=1010.
//  5 Reset asserted in CAPTURE -> done never pulses; busy=0, rdata=0, state IDLE next edge;
//    a new req is granted normally.
//  6 req0 dropped in APPLY -> done=01 still pulses in cycle 3; no second grant for requester 0.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank sequencer: op codes, FSM state
// encoding and the per-bit op -> J/K mapping.
package jk_ctrl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_APPLY   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Returns {J, K} for one bank bit; unselected bits always hold.
  function automatic logic [1:0] op_to_jk(input logic [1:0] op, input logic mask);
    logic [1:0] jk;
    case (op)
      OP_CLR:  jk = 2'b01;
      OP_SET:  jk = 2'b10;
      OP_TOG:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return mask ? jk : 2'b00;
  endfunction

endpackage

// File: rtl/jk_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on contention
// the requester pointed to by rr_ptr wins.
module jk_rr_arb2
  import jk_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic       gnt_id_o
);

  // Pure combinational pick; the pointer is owned by the sequencer.
  always_comb begin
    case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = rr_ptr_i;
      default: gnt_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Sequences one masked HOLD/CLR/SET/TOG op at a time onto an external
// JK flip-flop bank for two requesters: IDLE -> APPLY -> CAPTURE -> DONE.
module jk_bank_sequencer
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic             id_q, id_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] jk_j_q, jk_j_d, jk_k_q, jk_k_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             busy_q, busy_d;

  logic             gnt_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;

  jk_rr_arb2 u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_id_o (gnt_id)
  );

  assign sel_op   = gnt_id ? op1   : op0;
  assign sel_mask = gnt_id ? mask1 : mask0;

  // Next-state logic. The granted op/mask are latched directly as the J/K
  // pattern at grant, so later input changes cannot affect the op; J/K are
  // registered for exactly the APPLY cycle and zero everywhere else.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    jk_j_d   = '0;
    jk_k_d   = '0;
    done_d   = '0;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          id_d = gnt_id;
          for (int b = 0; b < WIDTH; b++)
            {jk_j_d[b], jk_k_d[b]} = op_to_jk(sel_op, sel_mask[b]);
          state_d = ST_APPLY;
        end
      end
      ST_APPLY:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        // Bank has clocked in J/K at the end of APPLY; q_in is post-op.
        rdata_d        = q_in;
        done_d[id_q]   = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        rr_ptr_d = ~id_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      id_q     <= 1'b0;
      rr_ptr_q <= 1'b0;
      jk_j_q   <= '0;
      jk_k_q   <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      jk_j_q   <= jk_j_d;
      jk_k_q   <= jk_k_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  assign jk_j  = jk_j_q;
  assign jk_k  = jk_k_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a 4-bit JK bank model closes the loop,
// expected {done, rdata} are queued at issue and popped on each done pulse.
module tb_jk_bank_sequencer;

  localparam int W = 4;
  localparam logic [1:0] HOLD = 2'b00, CLR = 2'b01, SET = 2'b10, TOG = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   req = '0;
  logic [1:0]   op0 = '0, op1 = '0;
  logic [W-1:0] mask0 = '0, mask1 = '0;
  logic [W-1:0] bank_q;
  logic [W-1:0] jk_j, jk_k, rdata;
  logic [1:0]   done;
  logic         busy;

  typedef struct packed {
    logic [1:0]   d;
    logic [W-1:0] r;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           done_cyc[$];
  int           cyc = 0;
  int           n_chk = 0, n_err = 0;
  logic [W-1:0] model_q = '0;

  jk_bank_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .op0(op0), .mask0(mask0), .op1(op1), .mask1(mask1),
    .q_in(bank_q), .jk_j(jk_j), .jk_k(jk_k),
    .done(done), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // JK bank on the same clock/reset: Q+ = J&~Q | ~K&Q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bank_q <= '0;
    else       bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued op.
  always @(negedge clk) begin
    if (!reset && done !== 2'b00) begin
      done_cyc.push_back(cyc);
      if (sb.size() == 0) chk("sb_unexpected_done", {30'b0, done}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_done", {30'b0, done}, {30'b0, e.d});
        chk("sb_rdata", {28'b0, rdata}, {28'b0, e.r});
      end
    end
  end

  function automatic logic [W-1:0] next_q(input logic [W-1:0] q, input logic [1:0] op,
                                          input logic [W-1:0] m);
    case (op)
      CLR:     return q & ~m;
      SET:     return q | m;
      TOG:     return q ^ m;
      default: return q;
    endcase
  endfunction

  task automatic do_reset(input logic [1:0] r);
    @(negedge clk);
    reset = 1'b1;
    req = r;
    model_q = '0;
    #1;
    chk("rst_jk_j", {28'b0, jk_j}, 0);
    chk("rst_jk_k", {28'b0, jk_k}, 0);
    chk("rst_done", {30'b0, done}, 0);
    chk("rst_rdata", {28'b0, rdata}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full transaction with cycle-exact checks of APPLY, CAPTURE and DONE.
  task automatic issue(input int id, input logic [1:0] op, input logic [W-1:0] m,
                       input bit drop_early);
    logic [W-1:0] ej, ek;
    logic [1:0]   oh;
    oh = (id == 0) ? 2'b01 : 2'b10;
    ej = (op == SET || op == TOG) ? m : '0;
    ek = (op == CLR || op == TOG) ? m : '0;
    @(negedge clk);
    req[id] = 1'b1;
    if (id == 0) begin op0 = op; mask0 = m; end
    else         begin op1 = op; mask1 = m; end
    sb.push_back('{d: oh, r: next_q(model_q, op, m)});
    model_q = next_q(model_q, op, m);
    @(negedge clk);  // APPLY
    chk("apply_busy", {31'b0, busy}, 1);
    chk("apply_j", {28'b0, jk_j}, {28'b0, ej});
    chk("apply_k", {28'b0, jk_k}, {28'b0, ek});
    if (drop_early) req[id] = 1'b0;
    if (id == 0) begin op0 = ~op; mask0 = ~m; end
    else         begin op1 = ~op; mask1 = ~m; end
    @(negedge clk);  // CAPTURE
    chk("capt_jk", {24'b0, jk_j, jk_k}, 0);
    chk("capt_busy", {31'b0, busy}, 1);
    @(negedge clk);  // DONE
    chk("done_lat", {30'b0, done}, {30'b0, oh});
    chk("done_busy", {31'b0, busy}, 1);
    req[id] = 1'b0;
  endtask

  initial begin
    int seen;
    do_reset(2'b00);

    // Single-requester ops across all encodings and masks.
    issue(0, SET,  4'b0101, 0);
    issue(1, TOG,  4'b1111, 0);
    issue(0, CLR,  4'b0000, 0);
    issue(1, HOLD, 4'b1111, 0);
    issue(0, CLR,  4'b0110, 0);
    issue(1, SET,  4'b0011, 0);

    // Contention from reset: 0, 1, 0 with one grant every 4 cycles.
    op0 = SET; mask0 = 4'b0001;
    op1 = SET; mask1 = 4'b0010;
    do_reset(2'b11);
    sb.push_back('{d: 2'b01, r: 4'b0001});
    sb.push_back('{d: 2'b10, r: 4'b0011});
    sb.push_back('{d: 2'b01, r: 4'b0011});
    done_cyc.delete();
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(negedge clk);
      if (done !== 2'b00) seen++;
    end
    req = 2'b00;
    chk("rr_count", seen, 3);
    @(negedge clk);
    if (done_cyc.size() >= 3) begin
      chk("rr_gap1", done_cyc[1] - done_cyc[0], 4);
      chk("rr_gap2", done_cyc[2] - done_cyc[1], 4);
    end else chk("rr_gap_samples", done_cyc.size(), 3);
    model_q = 4'b0011;

    // Reset in CAPTURE: op lost, no done, everything cleared.
    @(negedge clk);
    req = 2'b01; op0 = SET; mask0 = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req = 2'b00;
    model_q = '0;
    #1;
    chk("rcap_busy", {31'b0, busy}, 0);
    chk("rcap_rdata", {28'b0, rdata}, 0);
    chk("rcap_done", {30'b0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 2'b00 || busy !== 1'b0) seen++;
    end
    chk("rcap_quiet", seen, 0);
    issue(1, SET, 4'b0100, 0);

    // req dropped in APPLY: op still completes, no regrant afterwards.
    issue(0, TOG, 4'b0110, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 2'b00 || busy !== 1'b0) seen++;
    end
    chk("drop_no_regrant", seen, 0);

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
